sm_cfg_loader: RTL and testbench

SM_CFG_LOADER -- requirements
Module: sm_cfg_loader

---
 rtl/sm_cfg_pkg.sv | 21 ++
 rtl/sm_cfg_entry_chk.sv | 33 +++
 rtl/sm_cfg_loader.sv | 151 +++++++++++++++
 tb/tb_sm_cfg_loader.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sm_cfg_pkg.sv
// Shared constants for the switch-matrix configuration loader:
// sync word, side codes, entry width and FSM encoding.
package sm_cfg_pkg;

   localparam logic [7:0] SYNC = 8'hA5;
   localparam int DW = 6;

   localparam logic [2:0] SIDE_NONE   = 3'd0;
   localparam logic [2:0] SIDE_TOP    = 3'd1;
   localparam logic [2:0] SIDE_RIGHT  = 3'd2;
   localparam logic [2:0] SIDE_BOTTOM = 3'd3;
   localparam logic [2:0] SIDE_LEFT   = 3'd4;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_LOAD  = 2'd1,
      S_SUM   = 2'd2,
      S_CHECK = 2'd3
   } state_t;

endpackage

// File: rtl/sm_cfg_entry_chk.sv
// Legality of one config entry: side code in range and pin
// index within the pin count of the selected side.
module sm_cfg_entry_chk #(
   parameter int NTOP  = 5,
   parameter int NSIDE = 4,
   parameter int DW    = sm_cfg_pkg::DW
) (
   input  logic [DW-1:0] entry,
   output logic          legal
);
   import sm_cfg_pkg::*;

   logic [DW-4:0] idx;
   logic [2:0]    side;

   assign idx  = entry[DW-1:3];
   assign side = entry[2:0];

   always_comb begin
      legal = 1'b0;
      unique case (1'b1)
         (side == SIDE_NONE):
            legal = 1'b1;
         (side == SIDE_TOP) || (side == SIDE_BOTTOM):
            legal = (int'(idx) < NTOP);
         (side == SIDE_RIGHT) || (side == SIDE_LEFT):
            legal = (int'(idx) < NSIDE);
         default:
            legal = 1'b0;
      endcase
   end

endmodule

// File: rtl/sm_cfg_loader.sv
// Serial loader: sync, shadow-load all entries, verify checksum
// and legality, then commit the whole matrix config at once.
module sm_cfg_loader #(
   parameter int NTOP  = 5,
   parameter int NSIDE = 4,
   parameter int DW    = sm_cfg_pkg::DW
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                sin,
   input  logic                sin_valid,
   output logic                sin_ready,
   output logic [NTOP*DW-1:0]  cfg_top,
   output logic [NTOP*DW-1:0]  cfg_bottom,
   output logic [NSIDE*DW-1:0] cfg_left,
   output logic [NSIDE*DW-1:0] cfg_right,
   output logic                cfg_done,
   output logic                cfg_err,
   output logic                busy
);
   import sm_cfg_pkg::*;

   localparam int E  = 2*NTOP + 2*NSIDE;
   localparam int SW = E*DW;
   localparam int CW = $clog2(SW);
   localparam logic [CW-1:0] LAST_LOAD = CW'(SW-1);
   localparam logic [CW-1:0] LAST_SUM  = CW'(DW-1);

   state_t        state;
   logic [7:0]    win;
   logic [7:0]    win_n;
   logic [CW-1:0] cnt;
   logic [SW-1:0] shadow;
   logic [DW-1:0] csum;
   logic          acc;

   logic [DW-1:0] ent [E];
   logic [E-1:0]  legal;
   logic [DW-1:0] xsum;
   logic          frame_ok;

   logic [NTOP*DW-1:0]  top_n;
   logic [NTOP*DW-1:0]  bot_n;
   logic [NSIDE*DW-1:0] left_n;
   logic [NSIDE*DW-1:0] right_n;

   assign sin_ready = (state != S_CHECK);
   assign busy      = (state != S_IDLE);
   assign acc       = sin_valid && sin_ready;
   assign win_n     = {win[6:0], sin};

   // First entry shifted in ends up in the top DW bits
   for (genvar g = 0; g < E; g++) begin : g_ent
      assign ent[g] = shadow[(E-1-g)*DW +: DW];
      sm_cfg_entry_chk #(
         .NTOP  (NTOP),
         .NSIDE (NSIDE),
         .DW    (DW)
      ) u_chk (
         .entry (ent[g]),
         .legal (legal[g])
      );
   end

   for (genvar i = 0; i < NTOP; i++) begin : g_tb
      assign top_n[i*DW +: DW] = ent[i];
      assign bot_n[i*DW +: DW] = ent[NTOP+i];
   end

   for (genvar i = 0; i < NSIDE; i++) begin : g_lr
      assign left_n[i*DW +: DW]  = ent[2*NTOP+i];
      assign right_n[i*DW +: DW] = ent[2*NTOP+NSIDE+i];
   end

   always_comb begin
      xsum = '0;
      for (int i = 0; i < E; i++) begin
         xsum = xsum ^ ent[i];
      end
   end

   assign frame_ok = (xsum == csum) && (&legal);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         win        <= '0;
         cnt        <= '0;
         shadow     <= '0;
         csum       <= '0;
         cfg_top    <= '0;
         cfg_bottom <= '0;
         cfg_left   <= '0;
         cfg_right  <= '0;
         cfg_done   <= 1'b0;
         cfg_err    <= 1'b0;
      end else begin
         cfg_done <= 1'b0;
         cfg_err  <= 1'b0;
         unique case (state)
            S_IDLE: begin
               if (acc) begin
                  win <= win_n;
                  if (win_n == SYNC) begin
                     state <= S_LOAD;
                     cnt   <= '0;
                     win   <= '0;
                  end
               end
            end
            S_LOAD: begin
               if (acc) begin
                  shadow <= {shadow[SW-2:0], sin};
                  if (cnt == LAST_LOAD) begin
                     cnt   <= '0;
                     state <= S_SUM;
                  end else begin
                     cnt <= cnt + CW'(1);
                  end
               end
            end
            S_SUM: begin
               if (acc) begin
                  csum <= {csum[DW-2:0], sin};
                  if (cnt == LAST_SUM) begin
                     cnt   <= '0;
                     state <= S_CHECK;
                  end else begin
                     cnt <= cnt + CW'(1);
                  end
               end
            end
            S_CHECK: begin
               if (frame_ok) begin
                  cfg_top    <= top_n;
                  cfg_bottom <= bot_n;
                  cfg_left   <= left_n;
                  cfg_right  <= right_n;
                  cfg_done   <= 1'b1;
               end else begin
                  cfg_err <= 1'b1;
               end
               state <= S_IDLE;
               win   <= '0;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sm_cfg_loader.sv
// Directed scoreboard bench for the switch-matrix config loader.
module tb_sm_cfg_loader;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        sin = 1'b0;
   logic        sin_valid = 1'b0;
   logic        sin_ready;
   logic [29:0] cfg_top;
   logic [29:0] cfg_bottom;
   logic [23:0] cfg_left;
   logic [23:0] cfg_right;
   logic        cfg_done;
   logic        cfg_err;
   logic        busy;

   sm_cfg_loader dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .sin        (sin),
      .sin_valid  (sin_valid),
      .sin_ready  (sin_ready),
      .cfg_top    (cfg_top),
      .cfg_bottom (cfg_bottom),
      .cfg_left   (cfg_left),
      .cfg_right  (cfg_right),
      .cfg_done   (cfg_done),
      .cfg_err    (cfg_err),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          done;
      logic [29:0] top;
      logic [29:0] bot;
      logic [23:0] left;
      logic [23:0] right;
      time         t;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   failures = 0;
   int   lowcnt = 0;
   int   gapc = 0;
   bit   gap_en = 0;
   time  acc_t = 0;

   logic [5:0]  ent [18];
   logic [5:0]  cs;
   bit          fbits[$];
   logic [29:0] m_top = '0;
   logic [29:0] m_bot = '0;
   logic [23:0] m_left = '0;
   logic [23:0] m_right = '0;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic bit ent_legal(input logic [5:0] e);
      int idx;
      idx = int'(e[5:3]);
      case (e[2:0])
         3'd0:       return 1'b1;
         3'd1, 3'd3: return idx < 5;
         3'd2, 3'd4: return idx < 4;
         default:    return 1'b0;
      endcase
   endfunction

   always @(negedge clk) begin
      exp_t e;
      if (!sin_ready) lowcnt++;
      if (rst_n && (cfg_done || cfg_err)) begin
         chk("evt_pending", 64'(sb.size() > 0), 1);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("evt_done", cfg_done, e.done);
            chk("evt_err", cfg_err, !e.done);
            chk("evt_top", cfg_top, e.top);
            chk("evt_bottom", cfg_bottom, e.bot);
            chk("evt_left", cfg_left, e.left);
            chk("evt_right", cfg_right, e.right);
            chk("evt_latency", $time, e.t);
         end
      end
   end

   task automatic clear_ent();
      for (int i = 0; i < 18; i++) ent[i] = '0;
   endtask

   task automatic send_bit(input bit b);
      if (gap_en) begin
         gapc++;
         if (gapc % 3 == 0) begin
            sin_valid = 1'b0;
            @(negedge clk);
         end
      end
      sin = b;
      sin_valid = 1'b1;
      for (int k = 0; k < 4 && !sin_ready; k++) @(negedge clk);
      if (!sin_ready) chk("ready_wait", sin_ready, 1);
      @(posedge clk);
      acc_t = $time;
      @(negedge clk);
      sin_valid = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] v);
      for (int b = 7; b >= 0; b--) send_bit(v[b]);
   endtask

   task automatic send_frame(input int limit);
      logic [7:0] sv;
      logic [5:0] x;
      bit         ok;
      exp_t       e;
      int         low0;
      sv = 8'hA5;
      fbits.delete();
      for (int b = 7; b >= 0; b--) fbits.push_back(sv[b]);
      for (int k = 0; k < 18; k++)
         for (int b = 5; b >= 0; b--) fbits.push_back(ent[k][b]);
      for (int b = 5; b >= 0; b--) fbits.push_back(cs[b]);
      low0 = lowcnt;
      for (int i = 0; i < fbits.size() && i < limit; i++) begin
         send_bit(fbits[i]);
         if (i == 7) chk("busy_load", busy, 1);
      end
      if (limit < fbits.size()) return;
      x = '0;
      ok = 1'b1;
      for (int k = 0; k < 18; k++) begin
         x = x ^ ent[k];
         if (!ent_legal(ent[k])) ok = 1'b0;
      end
      if (x != cs) ok = 1'b0;
      if (ok) begin
         for (int i = 0; i < 5; i++) begin
            m_top[i*6 +: 6] = ent[i];
            m_bot[i*6 +: 6] = ent[5+i];
         end
         for (int i = 0; i < 4; i++) begin
            m_left[i*6 +: 6]  = ent[10+i];
            m_right[i*6 +: 6] = ent[14+i];
         end
      end
      e.done  = ok;
      e.top   = m_top;
      e.bot   = m_bot;
      e.left  = m_left;
      e.right = m_right;
      e.t     = acc_t + 15;
      sb.push_back(e);
      repeat (4) @(negedge clk);
      chk("ready_low_cycles", lowcnt - low0, 1);
      chk("sb_drained", sb.size(), 0);
   endtask

   initial begin
      #1;
      chk("rst_top", cfg_top, 0);
      chk("rst_bottom", cfg_bottom, 0);
      chk("rst_left", cfg_left, 0);
      chk("rst_right", cfg_right, 0);
      chk("rst_done", cfg_done, 0);
      chk("rst_err", cfg_err, 0);
      chk("rst_busy", busy, 0);
      chk("rst_ready", sin_ready, 1);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      clear_ent();
      ent[0] = 6'b001_010;
      cs = 6'b001_010;
      send_frame(1000);

      cs = 6'b000_000;
      send_frame(1000);

      clear_ent();
      ent[17] = 6'b100_001;
      cs = 6'b100_001;
      send_frame(1000);

      ent[17] = 6'b100_010;
      cs = 6'b100_010;
      send_frame(1000);

      clear_ent();
      ent[0] = 6'b000_101;
      cs = 6'b000_101;
      send_frame(1000);

      gap_en = 1'b1;
      send_byte(8'h5A);
      send_byte(8'hF0);
      clear_ent();
      ent[12] = 6'b011_011;
      ent[3] = 6'b001_001;
      cs = 6'b011_011 ^ 6'b001_001;
      send_frame(1000);
      gap_en = 1'b0;

      clear_ent();
      ent[6] = 6'b010_100;
      cs = 6'b010_100;
      send_frame(60);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_top", cfg_top, 0);
      chk("mid_rst_bottom", cfg_bottom, 0);
      chk("mid_rst_left", cfg_left, 0);
      chk("mid_rst_right", cfg_right, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_err", cfg_err, 0);
      m_top = '0;
      m_bot = '0;
      m_left = '0;
      m_right = '0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      send_frame(1000);

      repeat (3) @(negedge clk);
      chk("sb_final", sb.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
